// File: rtl/dac_write_sequencer.sv
// Feeds 12-bit DAC codes to the I2C controller as {addr, cmd, msb, lsb} frames,
// sequencing GO/END/ACK and retrying NACKed or timed-out frames.
module dac_write_sequencer #(
    parameter logic [7:0] SLAVE_ADDR = 8'hC0,
    parameter logic [7:0] CMD        = 8'h40,
    parameter int         MAX_RETRY  = 3,
    parameter int         TIMEOUT    = 63
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [11:0] SAMPLE,
    input  logic        SAMPLE_VALID,
    output logic        SAMPLE_READY,
    output logic [31:0] I2C_DATA,
    output logic        GO,
    input  logic        END,
    input  logic        ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic        OVERWRITE
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_RUN      = 3'd2,
        S_WAIT_END = 3'd3,
        S_CHECK    = 3'd4
    } state_t;

    state_t         state_q;
    logic [11:0]    pend_q;
    logic           pend_v_q;
    logic [31:0]    data_q;
    logic [RW-1:0]  retry_q;
    logic [TW-1:0]  tcnt_q;
    logic           to_q;
    logic           ready_q;
    logic           go_q;
    logic           busy_q;
    logic           done_q;
    logic           error_q;
    logic           overwrite_q;

    logic           consume_d;
    logic           bypass_d;
    logic           load_d;
    logic           fail_d;
    logic           can_retry_d;

    function automatic logic [31:0] frame_f(input logic [11:0] s);
        return {SLAVE_ADDR, CMD, s[11:4], s[3:0], 4'b0000};
    endfunction

    // A strobe arriving in IDLE with an empty slot goes straight to the frame,
    // which gives the two-cycle strobe-to-GO latency.
    always_comb begin
        consume_d   = (state_q == S_IDLE) && pend_v_q;
        bypass_d    = (state_q == S_IDLE) && !pend_v_q && SAMPLE_VALID;
        load_d      = SAMPLE_VALID && !bypass_d;
        fail_d      = ACK || to_q;
        can_retry_d = (retry_q < RETRY_MAX);
    end

    // Sequencer state, pending slot, counters and registered outputs.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            pend_q      <= 12'h000;
            pend_v_q    <= 1'b0;
            data_q      <= 32'h0000_0000;
            retry_q     <= '0;
            tcnt_q      <= '0;
            to_q        <= 1'b0;
            ready_q     <= 1'b0;
            go_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            overwrite_q <= 1'b0;
        end else begin
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            overwrite_q <= load_d && pend_v_q && !consume_d;

            if (load_d) begin
                pend_q   <= SAMPLE;
                pend_v_q <= 1'b1;
            end else if (consume_d) begin
                pend_v_q <= 1'b0;
            end else begin
                pend_v_q <= pend_v_q;
            end

            case (state_q)
                S_IDLE: begin
                    go_q <= 1'b0;
                    if (consume_d || bypass_d) begin
                        data_q  <= frame_f(consume_d ? pend_q : SAMPLE);
                        retry_q <= '0;
                        tcnt_q  <= '0;
                        to_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_ARM;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_ARM: begin
                    go_q    <= 1'b1;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (tcnt_q != TO_MAX) begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                    if (tcnt_q == TO_MAX) begin
                        to_q    <= 1'b1;
                        state_q <= S_CHECK;
                    end else if (!END) begin
                        state_q <= S_WAIT_END;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_WAIT_END: begin
                    if (tcnt_q != TO_MAX) begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                    if (END) begin
                        state_q <= S_CHECK;
                    end else if (tcnt_q == TO_MAX) begin
                        to_q    <= 1'b1;
                        state_q <= S_CHECK;
                    end else begin
                        state_q <= S_WAIT_END;
                    end
                end
                S_CHECK: begin
                    go_q <= 1'b0;
                    if (!fail_d) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (can_retry_d) begin
                        retry_q <= retry_q + RW'(1);
                        tcnt_q  <= '0;
                        to_q    <= 1'b0;
                        state_q <= S_ARM;
                    end else begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    go_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign SAMPLE_READY = ready_q;
    assign I2C_DATA     = data_q;
    assign GO           = go_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ERROR        = error_q;
    assign OVERWRITE    = overwrite_q;

endmodule
